subtree_sequencer: RTL
======================

# subtree_sequencer

Sequences the start/done handshakes of the N child instances under one generated hierarchy node: on a single start command it launches each enabled child in ascending index order, waits for that child's done or a programmable timeout, then moves to the next. It sits beside the hierarchy node as its controller, so the parent needs only a single start/done pair instead of N. Timeouts are recorded per child and the sequence always runs to completion.

## Interface
- N_CHILD, 10, number of child instances sequenced (≥1)
- TO_W, 8, width of the per-child timeout counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- en_mask_i  in  N_CHILD  children to run this sequence; latched on accepted start
- timeout_i  in  TO_W  per-child cycle limit; latched on accepted start; 0 = no timeout
- child_done_i  in  N_CHILD  completion pulse/level from each child
- child_start_o  out  N_CHILD  one-cycle start pulse to one child at a time
- busy_o  out  1  high from the accepted start through the FINISH cycle
- done_o  out  1  one-cycle pulse at sequence end
- cur_idx_o  out  $clog2(N_CHILD)  index of the active child; holds the last value when idle
- fail_mask_o  out  N_CHILD  children that timed out in the current or last sequence

## Operation
- Reset value of every output is 0. State is IDLE and all latched registers are 0.
- States are IDLE, LAUNCH, WAIT and FINISH.
- IDLE → start_i=1:
  - latch en_mask_i and timeout_i, clear fail_mask_o;
  - if the latched mask is 0, go to FINISH;
  - otherwise set idx to the lowest set bit and go to LAUNCH.
- LAUNCH: child_start_o[idx]=1 for this cycle only. Clear the counter, go to WAIT.
- WAIT:
  - child_done_i[idx]=1: child completes, advance.
  - Otherwise, with timeout≠0: counter increments; when counter+1 == timeout, set fail_mask_o[idx] and advance.
  - Done and timeout in the same cycle: done wins, fail bit is not set.
  - Timeout = 0: wait indefinitely.
- Advance: idx becomes the next set mask bit above idx and the state goes to LAUNCH. If no set bit remains, go to FINISH.
- FINISH: done_o=1 for one cycle, then IDLE.
- Ignored inputs:
  - start_i outside IDLE has no effect (no queuing);
  - child_done_i bits of non-active children are ignored in every state;
  - child_done_i[idx] asserted during LAUNCH is ignored; only WAIT samples it.
- Changes to en_mask_i or timeout_i mid-sequence have no effect.
- Asynchronous reset mid-sequence returns to IDLE immediately with all outputs 0. Any in-flight child start is abandoned.

## Timing
- All outputs are registered or decoded directly from registered state; there is no combinational input→output path.
- Start latency: start_i sampled at edge 0 → first child_start_o pulse in cycle 1.
- Inter-child gap: done sampled in WAIT at edge k → next child's start pulse in cycle k+1.
- Completion: last child's done sampled at edge k → done_o high in cycle k+1. busy_o falls in cycle k+2.
- Empty mask: start at edge 0 → done_o in cycle 1, with no child_start_o pulses.
- Timeout T: start pulse in cycle L, no done → fail bit set and advance after exactly T WAIT cycles (L+1..L+T).
- Back-to-back sequences: start_i may be accepted in the cycle after FINISH at the earliest.
- Counter width is TO_W and it never wraps, because it stops at the timeout compare. With timeout 0 it saturates at all-ones.

## Structure
- Shared package subtree_pkg holds:
  - the state enum seq_state_e (IDLE, LAUNCH, WAIT, FINISH);
  - localparam IDX_W = $clog2(N_CHILD) as a function.
- One sub-module, next_set_bit: combinational priority encoder returning the lowest set mask bit strictly above a given index, plus a "none" flag. The same module with index −1 (a valid flag) gives the first bit.
- The FSM, counter and fail-mask logic live in subtree_sequencer.

## Test plan
- Full mask 10'h3FF, timeout 8, each child returns done 3 cycles after its start → 10 start pulses in index order, each 4 cycles apart; done_o once; fail_mask_o = 0.
- Mask 10'b10_0010_0100, children answer immediately in WAIT → start pulses only on children 2, 5 and 9; cur_idx_o = 2, 5, 9; busy_o falls two cycles after child 9's done.
- Mask 10'h3FF, timeout 5, child 4 never responds → child 4 advances after 5 WAIT cycles; fail_mask_o = 10'h010; children 5–9 still run; done_o asserted.
- Mask 0 → done_o in cycle 1, no child_start_o activity. A second start_i during busy of a later run is ignored; exactly one done_o per accepted start.
- Child 3 asserts done in the same cycle its counter reaches timeout 4 → fail_mask_o[3] = 0. A spurious child_done_i[7] while child 3 is active is ignored.
- rst_n asserted while waiting on child 6 → all outputs 0 immediately; after release, a new start with mask 10'h001 completes normally.

Source files
------------

// File: rtl/subtree_pkg.sv
// Shared types and helpers for the subtree sequencer: FSM state encoding and
// the index-width function used by the top and its priority encoder.
package subtree_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

    // A single child still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtree_sequencer_next_set_bit.sv
// Combinational priority encoder: lowest set mask bit strictly above idx_i.
// With idx_vld_i low the index is treated as -1, giving the first set bit.
module next_set_bit
    import subtree_pkg::*;
#(
    parameter int N   = 10,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] idx_i,
    input  logic          idx_vld_i,
    output logic [IW-1:0] nxt_o,
    output logic          none_o
);

    always_comb begin
        nxt_o  = '0;
        none_o = 1'b1;
        // Descending scan so the lowest qualifying bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i] && (!idx_vld_i || (i > int'(idx_i)))) begin
                nxt_o  = IW'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/subtree_sequencer.sv
// Launches each enabled child in ascending index order, waiting for its done
// or a per-child timeout, then reports a single done pulse to the parent.
module subtree_sequencer
    import subtree_pkg::*;
#(
    parameter int N_CHILD = 10,
    parameter int TO_W    = 8,
    localparam int IDX_W  = idx_width(N_CHILD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [N_CHILD-1:0] en_mask_i,
    input  logic [TO_W-1:0]    timeout_i,
    input  logic [N_CHILD-1:0] child_done_i,
    output logic [N_CHILD-1:0] child_start_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [IDX_W-1:0]   cur_idx_o,
    output logic [N_CHILD-1:0] fail_mask_o
);

    seq_state_e         state_q;
    logic [N_CHILD-1:0] mask_q;
    logic [TO_W-1:0]    to_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TO_W-1:0]    cnt_q;
    logic [TO_W-1:0]    cnt_d;
    logic [N_CHILD-1:0] fail_q;
    logic [N_CHILD-1:0] start_q;
    logic               busy_q;
    logic               done_q;

    logic [N_CHILD-1:0] enc_mask;
    logic               enc_vld;
    logic [IDX_W-1:0]   nb_idx;
    logic               nb_none;
    logic [N_CHILD-1:0] nb_onehot;
    logic               child_done;
    logic               to_hit;
    logic               advance;

    // In IDLE the encoder looks at the live mask to find the first child;
    // afterwards it walks the latched mask above the current index.
    assign enc_mask  = (state_q == IDLE) ? en_mask_i : mask_q;
    assign enc_vld   = (state_q != IDLE);
    assign nb_onehot = N_CHILD'(1) << nb_idx;

    next_set_bit #(.N(N_CHILD)) u_next (
        .mask_i    (enc_mask),
        .idx_i     (idx_q),
        .idx_vld_i (enc_vld),
        .nxt_o     (nb_idx),
        .none_o    (nb_none)
    );

    assign cnt_d      = cnt_q + TO_W'(1);
    assign child_done = child_done_i[idx_q];
    assign to_hit     = (to_q != '0) && (cnt_d == to_q);
    assign advance    = child_done || to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            to_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mask_q <= en_mask_i;
                        to_q   <= timeout_i;
                        fail_q <= '0;
                        busy_q <= 1'b1;
                        if (nb_none) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            idx_q   <= nb_idx;
                            start_q <= nb_onehot;
                            state_q <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (advance) begin
                        // A done arriving on the timeout cycle counts as success.
                        if (!child_done) begin
                            fail_q[idx_q] <= 1'b1;
                        end
                        if (nb_none) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            idx_q   <= nb_idx;
                            start_q <= nb_onehot;
                            state_q <= LAUNCH;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_d;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign child_start_o = start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cur_idx_o     = idx_q;
    assign fail_mask_o   = fail_q;

endmodule
